// File: rtl/mux_reg_arb.sv
// N-channel, W-bit selector with a one-entry valid/ready output register.
// Round-robin arbitration is built only when MUX_REG_ARB_RR_EN is defined.
module mux_reg_arb #(
  parameter int NCH = 4,
  parameter int W   = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic            ld, gnt, rr_mode;
  logic [SELW-1:0] g;
  logic [W-1:0]    g_data;

  assign ld = !out_valid || out_ready;

`ifdef MUX_REG_ARB_RR_EN
  logic [SELW-1:0] rr_ptr;
  assign rr_mode = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign rr_mode     = 1'b0;
`endif

  always_comb begin
    gnt = 1'b0;
    g   = '0;
`ifdef MUX_REG_ARB_RR_EN
    if (rr_mode) begin
      // scan rr_ptr, rr_ptr+1, ... wrapping at NCH; first requester wins
      for (int i = 0; i < NCH; i++) begin
        int idx;
        idx = (int'(rr_ptr) + i) % NCH;
        if (!gnt && in_valid[idx]) begin
          gnt = 1'b1;
          g   = SELW'(idx);
        end
      end
    end else
`endif
    begin
      // compare against each legal index so an out-of-range sel never grants
      for (int k = 0; k < NCH; k++) begin
        if (!gnt && sel == SELW'(k) && in_valid[k]) begin
          gnt = 1'b1;
          g   = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int k = 0; k < NCH; k++)
      if (g == SELW'(k)) g_data = in_data[k*W +: W];
  end

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_rdy
      assign in_ready[k] = !resetn && ld && gnt && (g == SELW'(k));
    end
  endgenerate

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (ld) begin
      if (gnt) begin
        out_data  <= g_data;
        out_ch    <= g;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_REG_ARB_RR_EN
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)
      rr_ptr <= '0;
    else if (ld && gnt && rr_mode)
      rr_ptr <= (g == SELW'(NCH-1)) ? '0 : g + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mux_reg_arb.sv
// Scoreboard bench for mux_reg_arb: NCH=4 main instance plus an NCH=3 instance
// for the out-of-range select case.
module tb_mux_reg_arb;

  typedef struct packed { logic [7:0] d; logic [1:0] ch; } item_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [1:0]  sel, out_ch;
  logic        mode, out_valid, out_ready;
  logic [7:0]  out_data;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [1:0]  sel3, out_ch3;
  logic        mode3, out_valid3, out_ready3;
  logic [7:0]  out_data3;

  int    checks = 0;
  int    failures = 0;
  item_t sb[$];

  always #5 clk = ~clk;

  mux_reg_arb #(.NCH(4), .W(8)) u_dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready));

  mux_reg_arb #(.NCH(3), .W(8)) u_dut3 (
    .clk(clk), .resetn(resetn), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3));

  // output side of the scoreboard: every accepted output word must match the oldest expectation
  always @(negedge clk) begin
    if (!resetn && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: got data=%h ch=%0d, no word expected", out_data, out_ch);
      end else begin
        item_t e;
        e = sb.pop_front();
        if (out_data !== e.d || out_ch !== e.ch) begin
          failures++;
          $display("FAIL sb_word: got data=%h ch=%0d, want data=%h ch=%0d", out_data, out_ch, e.d, e.ch);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] chb(input int k);
    logic [31:0] v;
    v = in_data;
    return v[k*8 +: 8];
  endfunction

  task automatic test_reset();
    resetn = 1'b1; in_data = 32'h7E5A3C11; in_valid = 4'hF; sel = 2'd0; mode = 1'b0; out_ready = 1'b1;
    in_data3 = 24'h332211; in_valid3 = 3'b000; sel3 = 2'd0; mode3 = 1'b0; out_ready3 = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%h ch=%0d in_ready=%b, want 0/00/0/0000", out_valid, out_data, out_ch, in_ready);
    end
    nxt(); nxt();
    in_valid = 4'h0;
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_select();
    nxt();
    sel = 2'd2; in_valid = 4'hF; in_data = 32'h7EA53C11; out_ready = 1'b1; mode = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL select_ready: in_ready=%b want 0100", in_ready);
    end
    sb.push_back('{d: 8'hA5, ch: 2'd2});
    nxt();
    in_valid = 4'h0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      failures++;
      $display("FAIL select_out: valid=%b data=%h ch=%0d want 1/a5/2", out_valid, out_data, out_ch);
    end
    nxt();
  endtask

  task automatic test_backpressure();
    sel = 2'd1; in_valid = 4'hF; in_data = 32'h7E5A3C11; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_load_ready: in_ready=%b want 0010", in_ready);
    end
    sb.push_back('{d: 8'h3C, ch: 2'd1});
    for (int i = 0; i < 3; i++) begin
      nxt();
      out_ready = 1'b0; sel = 2'd3;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd1 || in_ready !== 4'h0) begin
        failures++;
        $display("FAIL bp_stall%0d: valid=%b data=%h ch=%0d in_ready=%b want 1/3c/1/0000", i, out_valid, out_data, out_ch, in_ready);
      end
    end
    nxt();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL bp_release_ready: in_ready=%b want 1000", in_ready);
    end
    sb.push_back('{d: 8'h7E, ch: 2'd3});
    nxt();
    in_valid = 4'h0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h7E || out_ch !== 2'd3) begin
      failures++;
      $display("FAIL bp_new_word: valid=%b data=%h ch=%0d want 1/7e/3", out_valid, out_data, out_ch);
    end
    nxt();
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [5] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
    in_data = $urandom();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nxt();
      sel = seq[i]; in_valid = 4'hF;
      @(negedge clk);
      checks++;
      if (in_ready !== (4'b0001 << seq[i])) begin
        failures++;
        $display("FAIL b2b_ready%0d: in_ready=%b want %b", i, in_ready, 4'b0001 << seq[i]);
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_bubble%0d: out_valid=%b want 1", i, out_valid);
        end
      end
      sb.push_back('{d: chb(int'(seq[i])), ch: seq[i]});
    end
    nxt();
    in_valid = 4'h0;
    nxt();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    nxt();
    sel = 2'd0; in_valid = 4'b0001; in_data = 32'h7E5A3CC7; out_ready = 1'b0;
    @(negedge clk);
    sb.push_back('{d: 8'hC7, ch: 2'd0});
    nxt();
    in_valid = 4'h0;
    @(negedge clk);
    #1;
    resetn = 1'b1; in_valid = 4'hF;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || in_ready !== 4'h0) begin
      failures++;
      $display("FAIL midreset: valid=%b data=%h ch=%0d in_ready=%b want 0/00/0/0000", out_valid, out_data, out_ch, in_ready);
    end
    sb.delete();
    nxt();
    in_valid = 4'h0; out_ready = 1'b1;
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_stale%0d: out_valid=%b want 0", i, out_valid);
      end
      nxt();
    end
  endtask

`ifdef MUX_REG_ARB_RR_EN
  task automatic test_round_robin();
    logic [3:0] vseq [9] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1001, 4'b1001, 4'hF, 4'hF};
    logic       mseq [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] gseq [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd2, 2'd1};
    in_data = $urandom(); out_ready = 1'b1; sel = 2'd2;
    for (int i = 0; i < 9; i++) begin
      in_valid = vseq[i]; mode = mseq[i];
      @(negedge clk);
      checks++;
      if (in_ready !== (4'b0001 << gseq[i])) begin
        failures++;
        $display("FAIL rr_grant%0d: in_ready=%b want %b", i, in_ready, 4'b0001 << gseq[i]);
      end
      sb.push_back('{d: chb(int'(gseq[i])), ch: gseq[i]});
      nxt();
    end
    in_valid = 4'h0; mode = 1'b0;
    nxt();
  endtask
`else
  task automatic test_mode_ignored();
    in_data = 32'h7E5A3C11; out_ready = 1'b1; mode = 1'b1; sel = 2'd2; in_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL mode_ignored_ready: in_ready=%b want 0100", in_ready);
    end
    sb.push_back('{d: 8'h5A, ch: 2'd2});
    nxt();
    sel = 2'd1; in_valid = 4'b1001;
    @(negedge clk);
    checks++;
    if (in_ready !== 4'h0) begin
      failures++;
      $display("FAIL mode_ignored_nogrant: in_ready=%b want 0000", in_ready);
    end
    nxt();
    in_valid = 4'h0; mode = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mode_ignored_drain: out_valid=%b want 0", out_valid);
    end
    nxt();
  endtask
`endif

  task automatic test_out_of_range();
    sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1; in_data3 = 24'h9C4B2E;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin
        failures++;
        $display("FAIL oor_sel%0d: in_ready=%b out_valid=%b want 000/0", i, in_ready3, out_valid3);
      end
      nxt();
    end
    sel3 = 2'd2;
    @(negedge clk);
    checks++;
    if (in_ready3 !== 3'b100) begin
      failures++;
      $display("FAIL nch3_ready: in_ready=%b want 100", in_ready3);
    end
    nxt();
    in_valid3 = 3'b000;
    @(negedge clk);
    checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'h9C || out_ch3 !== 2'd2) begin
      failures++;
      $display("FAIL nch3_out: valid=%b data=%h ch=%0d want 1/9c/2", out_valid3, out_data3, out_ch3);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`ifdef MUX_REG_ARB_RR_EN
    test_round_robin();
`else
    test_mode_ignored();
`endif
    test_out_of_range();
    nxt(); nxt();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d expected words never appeared, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
